// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared RISC-V decode constants and fetch-redirect state encoding.
package riscv_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_SQUASH = 1'b1
   } redirect_state_t;

   // Only R-type, store and branch formats carry a real rs2 field.
   function automatic logic uses_rs2(input logic [6:0] opc);
      return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
   endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Decode/execute-side bundle between the pipeline and the fetch redirect controller.
interface fetch_redirect_ctrl_if;

   logic [31:0] Instr_RD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        BranchTakenE;
   logic [31:0] BranchTargetE;
   logic        PcSrc;
   logic [31:0] PCTarget;
   logic        StallF;
   logic        ValidD;
   logic        ValidE;
   logic        MemReadE;
   logic [4:0]  RdE;
   logic [31:0] PCPlus4E;

   modport master (
      output Instr_RD, PCD, PCPlus4D, BranchTakenE, BranchTargetE,
      input  PcSrc, PCTarget, StallF, ValidD, ValidE, MemReadE, RdE, PCPlus4E
   );

   modport slave (
      input  Instr_RD, PCD, PCPlus4D, BranchTakenE, BranchTargetE,
      output PcSrc, PCTarget, StallF, ValidD, ValidE, MemReadE, RdE, PCPlus4E
   );

endinterface

// File: rtl/fetch_redirect_ctrl_hazard_detect.sv
// Load-use comparator: a load in E whose destination feeds the decode instruction.
module hazard_detect (
   input  logic       i_taken_e,
   input  logic       i_valid_d,
   input  logic       i_valid_e,
   input  logic       i_memread_e,
   input  logic [4:0] i_rd_e,
   input  logic [4:0] i_rs1,
   input  logic [4:0] i_rs2,
   input  logic       i_rs2_used,
   output logic       o_load_use
);

   logic w_src_match;

   assign w_src_match = (i_rd_e == i_rs1) || (i_rs2_used && (i_rd_e == i_rs2));

   assign o_load_use = !i_taken_e && i_valid_d && i_valid_e && i_memread_e &&
                       (i_rd_e != 5'd0) && w_src_match;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect control: taken-E and JAL redirects, load-use stall, E-stage tracking.
module fetch_redirect_ctrl
   import riscv_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   fetch_redirect_ctrl_if.slave  bus
);

   redirect_state_t r_state;
   redirect_state_t w_state_nxt;

   logic        r_valid_e;
   logic        r_memread_e;
   logic [4:0]  r_rd_e;
   logic [31:0] r_pcplus4_e;

   logic [6:0]  w_opcode;
   logic [4:0]  w_rd;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic        w_valid_d;
   logic        w_load_use;
   logic        w_jal;
   logic        w_bubble;
   logic [31:0] w_jal_imm;
   logic        w_pcsrc;
   logic [31:0] w_pctarget;
   logic        w_stallf;

   assign w_opcode  = bus.Instr_RD[6:0];
   assign w_rd      = bus.Instr_RD[11:7];
   assign w_rs1     = bus.Instr_RD[19:15];
   assign w_rs2     = bus.Instr_RD[24:20];
   assign w_valid_d = (r_state == ST_RUN);
   assign w_jal_imm = {{11{bus.Instr_RD[31]}}, bus.Instr_RD[31], bus.Instr_RD[19:12],
                       bus.Instr_RD[20], bus.Instr_RD[30:21], 1'b0};

   hazard_detect u_hazard (
      .i_taken_e   (bus.BranchTakenE),
      .i_valid_d   (w_valid_d),
      .i_valid_e   (r_valid_e),
      .i_memread_e (r_memread_e),
      .i_rd_e      (r_rd_e),
      .i_rs1       (w_rs1),
      .i_rs2       (w_rs2),
      .i_rs2_used  (uses_rs2(w_opcode)),
      .o_load_use  (w_load_use)
   );

   // A load-use stall holds the JAL in decode, so its redirect waits a cycle.
   assign w_jal    = w_valid_d && !bus.BranchTakenE && !w_load_use && (w_opcode == OPC_JAL);
   assign w_bubble = bus.BranchTakenE || w_load_use || !w_valid_d;

   always_comb begin
      w_pcsrc     = 1'b0;
      w_pctarget  = '0;
      w_stallf    = 1'b0;
      w_state_nxt = ST_RUN;
      if (bus.BranchTakenE) begin
         w_pcsrc     = 1'b1;
         w_pctarget  = bus.BranchTargetE;
         w_state_nxt = ST_SQUASH;
      end else if (w_load_use) begin
         w_stallf = 1'b1;
      end else if (w_jal) begin
         w_pcsrc     = 1'b1;
         w_pctarget  = bus.PCD + w_jal_imm;
         w_state_nxt = ST_SQUASH;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid_e   <= 1'b0;
         r_memread_e <= 1'b0;
         r_rd_e      <= '0;
         r_pcplus4_e <= '0;
      end else if (w_bubble) begin
         r_valid_e   <= 1'b0;
         r_memread_e <= 1'b0;
         r_rd_e      <= '0;
         r_pcplus4_e <= '0;
      end else begin
         r_valid_e   <= 1'b1;
         r_memread_e <= (w_opcode == OPC_LOAD);
         r_rd_e      <= w_rd;
         r_pcplus4_e <= bus.PCPlus4D;
      end
   end

   assign bus.PcSrc    = w_pcsrc;
   assign bus.PCTarget = w_pctarget;
   assign bus.StallF   = w_stallf;
   assign bus.ValidD   = w_valid_d;
   assign bus.ValidE   = r_valid_e;
   assign bus.MemReadE = r_memread_e;
   assign bus.RdE      = r_rd_e;
   assign bus.PCPlus4E = r_pcplus4_e;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed scoreboard bench for fetch_redirect_ctrl; inputs change after posedge, outputs checked on negedge.
module tb_fetch_redirect_ctrl;

   logic clk;
   logic rst;
   logic obs_valid;

   fetch_redirect_ctrl_if bus ();

   fetch_redirect_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        pcsrc;
      logic [31:0] tgt;
      logic        stall;
      logic        vd;
      logic        ve;
      logic        mr;
      logic [4:0]  rd;
      logic [31:0] p4;
   } exp_t;

   exp_t exp_q[$];
   int   checks;
   int   errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [11:0] imm);
      return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
   endfunction

   function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
      return enc_i(12'd0, rs1, 3'b010, rd, 7'b0000011);
   endfunction

   function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic step(input logic [31:0] instr, input logic [31:0] pcd, input logic bt,
                       input logic [31:0] btgt, input logic r,
                       input logic e_pcsrc, input logic [31:0] e_tgt, input logic e_stall,
                       input logic e_vd, input logic e_ve, input logic e_mr,
                       input logic [4:0] e_rd, input logic [31:0] e_p4);
      exp_t e;
      @(posedge clk);
      #1;
      rst               = r;
      bus.Instr_RD      = instr;
      bus.PCD           = pcd;
      bus.PCPlus4D      = pcd + 32'd4;
      bus.BranchTakenE  = bt;
      bus.BranchTargetE = btgt;
      e.pcsrc = e_pcsrc; e.tgt = e_tgt; e.stall = e_stall; e.vd = e_vd;
      e.ve = e_ve; e.mr = e_mr; e.rd = e_rd; e.p4 = e_p4;
      exp_q.push_back(e);
      obs_valid = 1'b1;
   endtask

   always @(negedge clk) begin
      if (obs_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow got empty queue expected entry at %0t", $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("PcSrc",    {31'd0, bus.PcSrc},    {31'd0, e.pcsrc});
            chk("PCTarget", bus.PCTarget,          e.tgt);
            chk("StallF",   {31'd0, bus.StallF},   {31'd0, e.stall});
            chk("ValidD",   {31'd0, bus.ValidD},   {31'd0, e.vd});
            chk("ValidE",   {31'd0, bus.ValidE},   {31'd0, e.ve});
            chk("MemReadE", {31'd0, bus.MemReadE}, {31'd0, e.mr});
            chk("RdE",      {27'd0, bus.RdE},      {27'd0, e.rd});
            chk("PCPlus4E", bus.PCPlus4E,          e.p4);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      obs_valid = 1'b0;
      rst = 1'b1;
      bus.Instr_RD = enc_addi(5'd0, 5'd0, 12'd0);
      bus.PCD = '0;
      bus.PCPlus4D = 32'd4;
      bus.BranchTakenE = 1'b0;
      bus.BranchTargetE = '0;

      // reset state
      step(enc_addi(0,0,0),     32'h00, 0, 0, 1,  0, 0, 0, 1,  0, 0, 0, 32'h00);
      step(enc_addi(0,0,0),     32'h00, 0, 0, 1,  0, 0, 0, 1,  0, 0, 0, 32'h00);
      // ADDI stream
      step(enc_addi(1,0,1),     32'h00, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 32'h00);
      step(enc_addi(2,1,2),     32'h04, 0, 0, 0,  0, 0, 0, 1,  1, 0, 1, 32'h04);
      step(enc_addi(3,2,3),     32'h08, 0, 0, 0,  0, 0, 0, 1,  1, 0, 2, 32'h08);
      // LW x5 then ADD x6,x5,x1: one-cycle stall, bubble, ADD enters after
      step(enc_lw(5,1),         32'h0C, 0, 0, 0,  0, 0, 0, 1,  1, 0, 3, 32'h0C);
      step(enc_add(6,5,1),      32'h10, 0, 0, 0,  0, 0, 1, 1,  1, 1, 5, 32'h10);
      step(enc_add(6,5,1),      32'h10, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 32'h00);
      // LW x0 then user of x0: no stall
      step(enc_lw(0,1),         32'h14, 0, 0, 0,  0, 0, 0, 1,  1, 0, 6, 32'h14);
      step(enc_add(7,0,0),      32'h18, 0, 0, 0,  0, 0, 0, 1,  1, 1, 0, 32'h18);
      // rs2 hazard on R-type; same bits in an I-type immediate do not stall
      step(enc_lw(8,1),         32'h1C, 0, 0, 0,  0, 0, 0, 1,  1, 0, 7, 32'h1C);
      step(enc_add(9,1,8),      32'h20, 0, 0, 0,  0, 0, 1, 1,  1, 1, 8, 32'h20);
      step(enc_add(9,1,8),      32'h20, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 32'h00);
      step(enc_lw(8,1),         32'h24, 0, 0, 0,  0, 0, 0, 1,  1, 0, 9, 32'h24);
      step(enc_addi(10,1,8),    32'h28, 0, 0, 0,  0, 0, 0, 1,  1, 1, 8, 32'h28);
      // JAL +16 at 0x20; a JAL in the squashed slot is ignored
      step(enc_jal(1,21'd16),   32'h20, 0, 0, 0,  1, 32'h30, 0, 1,  1, 0, 10, 32'h2C);
      step(enc_jal(1,21'd16),   32'h24, 0, 0, 0,  0, 0, 0, 0,  1, 0, 1, 32'h24);
      // JAL -8 at 0x4 wraps
      step(enc_jal(0,21'h1FFFF8), 32'h04, 0, 0, 0, 1, 32'hFFFFFFFC, 0, 1, 0, 0, 0, 32'h00);
      step(enc_addi(11,0,0),    32'h30, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 32'h08);
      // taken-E beats concurrent load-use and JAL, then back-to-back taken-E
      step(enc_lw(5,1),         32'h40, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 32'h00);
      step(enc_jal(1,21'h028000), 32'h44, 1, 32'h10, 0, 1, 32'h10, 0, 1, 1, 1, 5, 32'h44);
      step(enc_addi(11,0,0),    32'h48, 1, 32'h100, 0, 1, 32'h100, 0, 0, 0, 0, 0, 32'h00);
      step(enc_addi(11,0,0),    32'h10, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 32'h00);
      step(enc_addi(12,0,0),    32'h100, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 32'h00);
      // reset pulse during SQUASH
      step(enc_jal(0,21'd16),   32'h104, 0, 0, 0, 1, 32'h114, 0, 1, 1, 0, 12, 32'h104);
      step(enc_addi(1,0,0),     32'h108, 0, 0, 1, 0, 0, 0, 1,  0, 0, 0, 32'h00);
      step(enc_addi(13,0,0),    32'h114, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 32'h00);
      // reset pulse during a load-use stall
      step(enc_lw(5,1),         32'h118, 0, 0, 0, 0, 0, 0, 1,  1, 0, 13, 32'h118);
      step(enc_add(6,5,1),      32'h11C, 0, 0, 1, 0, 0, 0, 1,  0, 0, 0, 32'h00);
      step(enc_add(6,5,1),      32'h11C, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 32'h00);

      @(posedge clk);
      #1;
      obs_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d left expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_redirect_ctrl.md
FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 Instr_RD  in  32  instruction in decode, from fetch stage.
REQ-005 PCD  in  32  PC of decode instruction.
REQ-006 PCPlus4D  in  32  PCD+4 (not used for targets; carried for E-stage link only).
REQ-007 BranchTakenE  in  1  execute resolved a taken branch or JALR.
REQ-008 BranchTargetE  in  32  execute redirect target.
REQ-009 PcSrc  out  1  to fetch: select PCTarget.
REQ-010 PCTarget  out  32  to fetch: redirect address.
REQ-011 StallF  out  1  to fetch: hold PC and decode registers.
REQ-012 ValidD  out  1  decode instruction is real (not squashed).
REQ-013 ValidE, MemReadE, RdE[4:0], PCPlus4E[31:0]  out  E-stage tracking registers.

Function
REQ-014 Decode fields: opcode=Instr_RD[6:0], rd=[11:7], rs1=[19:15], rs2=[24:20]; rs2 used only for opcodes 0110011, 0100011, 1100011.
REQ-015 FSM states RUN and SQUASH; SQUASH means the instruction arriving in decode next cycle is wrong-path.
REQ-016 ValidD SHALL be 0 in SQUASH, else 1.
REQ-017 Taken-E redirect (BranchTakenE=1): PcSrc=1, PCTarget=BranchTargetE, StallF=0, current decode instruction not captured into E, next state SQUASH; highest priority.
REQ-018 JAL redirect (opcode 1101111, ValidD=1, no taken-E): PcSrc=1, PCTarget=PCD+sign-extended J-immediate (bits {31,19:12,20,30:21,0}), modulo 2^32; decode instruction captured into E normally; next state SQUASH.
REQ-019 Load-use (ValidD=1, no taken-E, ValidE=1, MemReadE=1, RdE!=0, RdE equals rs1 or used rs2): StallF=1, PcSrc=0, bubble inserted into E; JAL redirect suppressed that cycle.
REQ-020 Otherwise PcSrc=0, PCTarget=32'h0, StallF=0.
REQ-021 SQUASH lasts exactly one cycle and returns to RUN unless a new redirect occurs that cycle (taken-E stays in SQUASH).
REQ-022 E-register update each edge: bubble (ValidE=0, MemReadE=0, RdE=0, PCPlus4E=0) on taken-E, load-use, or ValidD=0; else ValidE=1, MemReadE=(opcode==0000011), RdE=rd, PCPlus4E=PCPlus4D.
REQ-023 PcSrc, PCTarget, StallF SHALL be combinational from inputs and registered state (zero-cycle latency); redirect takes effect at fetch on the next edge.
REQ-024 Load-use stall SHALL last exactly one cycle since the bubble clears MemReadE.

Reset
REQ-025 On rst: state RUN, ValidE=0, MemReadE=0, RdE=0, PCPlus4E=0; hence ValidD=1, StallF=0, PcSrc=0 unless BranchTakenE is driven.
REQ-026 Reset asserted mid-SQUASH or mid-stall SHALL abort it immediately, with no redirect pending after release.

Structure
REQ-027 Opcode constants (LOAD, STORE, OP, BRANCH, JAL) and the state enum SHALL live in shared package riscv_pkg.
REQ-028 Load-use comparator SHALL be sub-module hazard_detect; J-immediate/target generation stays inline.

Verification
REQ-029 Reset release, stream of ADDI at PCD 0,4,8 -> PcSrc=0, StallF=0, ValidD=1, ValidE=1 from cycle 2.
REQ-030 LW x5 then ADD x6,x5,x1 -> StallF=1 one cycle, ValidE=0 next cycle, ADD enters E after; LW x0 followed by a user of x0 -> no stall.
REQ-031 JAL imm=+16 at PCD=0x20 -> PcSrc=1, PCTarget=0x30; ValidD=0 next cycle; JAL imm=-8 at PCD=0x4 -> PCTarget=0xFFFFFFFC.
REQ-032 BranchTakenE=1, target 0x10, concurrent load-use and JAL in decode -> PcSrc=1, PCTarget=0x10, StallF=0, E bubble, ValidD=0 next cycle.
REQ-033 Back-to-back taken-E two cycles -> remains SQUASH, second target wins, RUN one cycle after.
REQ-034 rst pulse during SQUASH -> ValidD=1 and all E registers 0 immediately.
